// File: rtl/op_pkg.sv
// rtl/op_pkg.sv - opcode and source encodings shared by the decoder and src_queue
package op_pkg;

    localparam logic [3:0] WRITE_A = 4'b0001;
    localparam logic [3:0] WRITE_B = 4'b0010;
    localparam logic [3:0] READ_C  = 4'b1011;

    localparam logic [1:0] SRC_A  = 2'b00;
    localparam logic [1:0] SRC_B  = 2'b10;
    localparam logic [1:0] SRC_RD = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and first-word-fall-through head
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Caller gates push/pop against full/empty; pointers wrap on their natural width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/src_queue.sv
// rtl/src_queue.sv - operand queue fed by the opcode decoder, with sticky error reporting
import op_pkg::*;

module src_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    input  logic                     write,
    input  logic [1:0]               source,
    input  logic [DATA_W-1:0]        a_data,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     clr_err,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err_illegal,
    output logic                     err_ovf,
    output logic                     err_udf
);
    logic              is_push;
    logic              is_pop;
    logic              is_illegal;
    logic              push_ok;
    logic              pop_ok;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] head;

    // Every decode term is qualified by op_valid so undriven write/source never leak in.
    always_comb begin
        is_push    = op_valid && write && ((source == SRC_A) || (source == SRC_B));
        is_pop     = op_valid && !write && (source == SRC_RD);
        is_illegal = op_valid && !is_push && !is_pop;
        push_data  = (source == SRC_B) ? b_data : a_data;
        push_ok    = is_push && !full;
        pop_ok     = is_pop && !empty;
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (pop_ok),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Error flags are set-dominant: a new event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            err_illegal <= 1'b0;
            err_ovf     <= 1'b0;
            err_udf     <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= head;
            end
            err_illegal <= is_illegal           || (err_illegal && !clr_err);
            err_ovf     <= (is_push && full)    || (err_ovf && !clr_err);
            err_udf     <= (is_pop && empty)    || (err_udf && !clr_err);
        end
    end

endmodule

// File: tb/tb_src_queue.sv
// tb/tb_src_queue.sv - directed table, corner sequences and randomized model check for src_queue
module tb_src_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid;
    logic             write;
    logic [1:0]       source;
    logic [7:0]       a_data;
    logic [7:0]       b_data;
    logic             clr_err;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             err_illegal;
    logic             err_ovf;
    logic             err_udf;

    int checks   = 0;
    int failures = 0;

    // Reference state kept at the level of the queue's rules.
    logic [7:0] q[$];
    logic       m_rv;
    logic [7:0] m_rd;
    logic       m_ill, m_ovf, m_udf;

    always #5 clk = ~clk;

    src_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .write(write), .source(source),
        .a_data(a_data), .b_data(b_data), .clr_err(clr_err),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .full(full), .empty(empty),
        .err_illegal(err_illegal), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    typedef struct {
        logic       v;
        logic       w;
        logic [1:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic       erv;
        logic [7:0] erd;
        logic [2:0] ecnt;
        logic [2:0] eerr;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic v, input logic w, input logic [1:0] s,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic c, input logic r);
        logic ill, ovf, udf;
        ill = 0; ovf = 0; udf = 0;
        if (r) begin
            q.delete();
            m_rv = 0; m_rd = 0; m_ill = 0; m_ovf = 0; m_udf = 0;
        end else begin
            m_rv = 0;
            if (v) begin
                if (w === 1'b1 && (s === 2'b00 || s === 2'b10)) begin
                    if (q.size() < DEPTH) q.push_back(s === 2'b10 ? b : a);
                    else ovf = 1;
                end else if (w === 1'b0 && s === 2'b11) begin
                    if (q.size() > 0) begin
                        m_rd = q.pop_front();
                        m_rv = 1;
                    end else udf = 1;
                end else ill = 1;
            end
            m_ill = ill | (m_ill & ~c);
            m_ovf = ovf | (m_ovf & ~c);
            m_udf = udf | (m_udf & ~c);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic r);
        op_valid = v; write = w; source = s; a_data = a; b_data = b; clr_err = c; rst = r;
        @(posedge clk);
        #1;
        model_update(v, w, s, a, b, c, r);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(m_rd));
        chk({tag, ".count"},    32'(count),    32'(q.size()));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        chk({tag, ".errs"},     32'({err_illegal, err_ovf, err_udf}), 32'({m_ill, m_ovf, m_udf}));
    endtask

    initial begin
        // v w s a b clr | rv rd cnt err{ill,ovf,udf}
        vecs[0]  = '{1, 1, 2'b00, 8'h11, 8'h99, 0, 0, 8'h00, 3'd1, 3'b000};
        vecs[1]  = '{1, 1, 2'b10, 8'h33, 8'h22, 0, 0, 8'h00, 3'd2, 3'b000};
        vecs[2]  = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h11, 3'd1, 3'b000};
        vecs[3]  = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h22, 3'd0, 3'b000};
        vecs[4]  = '{1, 1, 2'b00, 8'h01, 8'h00, 0, 0, 8'h22, 3'd1, 3'b000};
        vecs[5]  = '{1, 1, 2'b00, 8'h02, 8'h00, 0, 0, 8'h22, 3'd2, 3'b000};
        vecs[6]  = '{1, 1, 2'b00, 8'h03, 8'h00, 0, 0, 8'h22, 3'd3, 3'b000};
        vecs[7]  = '{1, 1, 2'b00, 8'h04, 8'h00, 0, 0, 8'h22, 3'd4, 3'b000};
        vecs[8]  = '{1, 1, 2'b00, 8'h05, 8'h00, 0, 0, 8'h22, 3'd4, 3'b010};
        vecs[9]  = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h01, 3'd3, 3'b010};
        vecs[10] = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h02, 3'd2, 3'b010};
        vecs[11] = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h03, 3'd1, 3'b010};
        vecs[12] = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h04, 3'd0, 3'b010};
        vecs[13] = '{0, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h04, 3'd0, 3'b000};
        vecs[14] = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 0, 8'h04, 3'd0, 3'b001};
        vecs[15] = '{0, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h04, 3'd0, 3'b000};
        vecs[16] = '{1, 0, 2'b11, 8'h00, 8'h00, 1, 0, 8'h04, 3'd0, 3'b001};
        vecs[17] = '{0, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h04, 3'd0, 3'b000};
        vecs[18] = '{1, 1, 2'b11, 8'h00, 8'h00, 0, 0, 8'h04, 3'd0, 3'b100};
        vecs[19] = '{1, 1, 2'b00, 8'h55, 8'h00, 0, 0, 8'h04, 3'd1, 3'b100};
        vecs[20] = '{1, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h04, 3'd1, 3'b100};
        vecs[21] = '{1, 1, 2'b01, 8'h66, 8'h77, 0, 0, 8'h04, 3'd1, 3'b100};
        vecs[22] = '{0, 1, 2'b00, 8'h88, 8'h00, 0, 0, 8'h04, 3'd1, 3'b100};
        vecs[23] = '{0, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h04, 3'd1, 3'b000};
        vecs[24] = '{1, 0, 2'b11, 8'h00, 8'h00, 0, 1, 8'h55, 3'd0, 3'b000};

        step(0, 0, 2'b00, 0, 0, 0, 1);
        step(0, 0, 2'b00, 0, 0, 0, 1);
        chk("reset.rd_valid", 32'(rd_valid), 0);
        chk("reset.rd_data", 32'(rd_data), 0);
        chk("reset.full", 32'(full), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'bx, 2'bxx, 8'hxx, 8'hxx, 0, 0);
            chk("idle.count", 32'(count), 0);
            chk("idle.empty", 32'(empty), 1);
            chk("idle.rd_valid", 32'(rd_valid), 0);
            chk("idle.errs", 32'({err_illegal, err_ovf, err_udf}), 0);
        end

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].v, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].clr, 0);
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].erv));
            chk($sformatf("vec%0d.rd_data", i),  32'(rd_data),  32'(vecs[i].erd));
            chk($sformatf("vec%0d.count", i),    32'(count),    32'(vecs[i].ecnt));
            chk($sformatf("vec%0d.full", i),     32'(full),     32'(vecs[i].ecnt == 3'd4));
            chk($sformatf("vec%0d.empty", i),    32'(empty),    32'(vecs[i].ecnt == 3'd0));
            chk($sformatf("vec%0d.errs", i),     32'({err_illegal, err_ovf, err_udf}), 32'(vecs[i].eerr));
        end

        // Unknown write bit with an undefined source code is still illegal.
        step(1, 1'bx, 2'b01, 8'h00, 8'h00, 0, 0);
        chk("xillegal.err_illegal", 32'(err_illegal), 1);
        chk("xillegal.count", 32'(count), 0);
        chk("xillegal.rd_valid", 32'(rd_valid), 0);
        step(0, 0, 2'b00, 0, 0, 1, 0);

        for (int i = 0; i < 10; i++) begin
            step(1, 1, (i % 2) ? 2'b10 : 2'b00, 8'(i * 17 + 3), 8'(i * 17 + 3), 0, 0);
            chk("wrap.count_after_push", 32'(count), 1);
            step(1, 0, 2'b11, 0, 0, 0, 0);
            chk("wrap.rd_valid", 32'(rd_valid), 1);
            chk("wrap.rd_data", 32'(rd_data), 32'(i * 17 + 3));
        end
        step(0, 0, 2'b00, 0, 0, 0, 0);
        chk("strobe_one_cycle", 32'(rd_valid), 0);

        for (int i = 0; i < 3; i++) step(1, 1, 2'b00, 8'hA0 + 8'(i), 0, 0, 0);
        chk("prerst.count", 32'(count), 3);
        step(1, 0, 2'b11, 0, 0, 0, 1);
        chk("midrst.count", 32'(count), 0);
        chk("midrst.rd_valid", 32'(rd_valid), 0);
        chk("midrst.rd_data", 32'(rd_data), 0);
        chk("midrst.empty", 32'(empty), 1);

        for (int n = 0; n < 800; n++) begin
            int r;
            logic c;
            r = $urandom_range(0, 99);
            c = ($urandom_range(0, 9) == 0);
            if (r < 2)       step(1, 0, 2'b11, 0, 0, c, 1);
            else if (r < 40) step(1, 1, 2'b00, 8'($urandom), 8'($urandom), c, 0);
            else if (r < 55) step(1, 1, 2'b10, 8'($urandom), 8'($urandom), c, 0);
            else if (r < 85) step(1, 0, 2'b11, 8'($urandom), 8'($urandom), c, 0);
            else if (r < 90) begin
                logic [2:0] p;
                p = 3'($urandom_range(0, 4));
                case (p)
                    3'd0:    step(1, 1, 2'b11, 0, 0, c, 0);
                    3'd1:    step(1, 0, 2'b00, 0, 0, c, 0);
                    3'd2:    step(1, 0, 2'b10, 0, 0, c, 0);
                    3'd3:    step(1, 1, 2'b01, 0, 0, c, 0);
                    default: step(1, 0, 2'b01, 0, 0, c, 0);
                endcase
            end else step(0, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), c, 0);
            chk_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/src_queue.md
# src_queue

Operand queue sitting directly downstream of the opcode decoder: each cycle it consumes the decoder's registered `write`/`source` pair, qualified by a valid strobe. Write ops capture operand A or B into a DEPTH-entry FIFO. The read op (`source` 2'b11, `write` 0) pops the head onto a one-cycle read strobe. Illegal pairs, overflow and underflow are reported on sticky error flags.

## Interface
Parameters:
- `DATA_W`, 8, operand/result width
- `DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `op_valid`  in  1  `write`/`source` are meaningful this cycle
- `write`  in  1  from decoder: 1 = push, 0 = read
- `source`  in  2  from decoder: 2'b00 = A, 2'b10 = B, 2'b11 = read head
- `a_data`  in  DATA_W  operand A
- `b_data`  in  DATA_W  operand B
- `clr_err`  in  1  clears sticky error flags
- `rd_valid`  out  1  one-cycle strobe, `rd_data` valid
- `rd_data`  out  DATA_W  popped entry
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `err_illegal`  out  1  sticky: illegal op pair seen
- `err_ovf`  out  1  sticky: push while full
- `err_udf`  out  1  sticky: read while empty

## Operation
- The op is sampled only when `op_valid`=1. With `op_valid`=0, `write`/`source` are ignored, including X values.
- Legal pairs:
  - (1, 00): push `a_data`.
  - (1, 10): push `b_data`.
  - (0, 11): pop.
- Any other pair with `op_valid`=1 sets `err_illegal`. FIFO, `count` and `rd_valid` are unaffected.
- Push when not full: the data is written at the write pointer, the write pointer increments modulo DEPTH, and `count`+1.
- Push when full: the data is dropped, `err_ovf` is set, and pointers and `count` are unchanged.
- Pop when not empty: `rd_data` = head entry, `rd_valid`=1, the read pointer increments modulo DEPTH, and `count`−1.
- Pop when empty: `rd_valid`=0, `rd_data` holds its previous value, and `err_udf` is set.
- At most one op per cycle, so push and pop are never simultaneous.
- Error flags:
  - Set-dominant over `clr_err` in the same cycle.
  - Otherwise `clr_err`=1 clears all three on the next edge.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `count` is one bit wider, so full and empty are unambiguous.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `count`=0, `empty`=1, `full`=0, all `err_*`=0, both pointers 0. FIFO contents are don't-care.
- `rst` asserted mid-operation flushes the queue. An op presented in the same cycle as `rst` is discarded.
- Latency: an op sampled at edge N has all effects (`count`, flags, `rd_valid`/`rd_data`) visible after edge N.
- `rd_valid` is high for exactly one cycle per successful pop.
- Back-to-back pops drain one entry per cycle.
- Push-to-pop:
  - A push at edge N is poppable by an op sampled at edge N+1.
  - Minimum push-to-`rd_valid` is 2 edges.
- `full`/`empty` are combinational decodes of the registered `count`, with no extra cycle.
- No ready/backpressure on `rd_*`; the consumer must accept every strobe.

## Structure
- Shared package `op_pkg` holds:
  - Opcode constants `WRITE_A`=4'b0001, `WRITE_B`=4'b0010, `READ_C`=4'b1011.
  - Source encodings `SRC_A`=2'b00, `SRC_B`=2'b10, `SRC_RD`=2'b11.
  - The decoder and this block both use these.
- One sub-module, `sync_fifo`, parameterised on `DATA_W`/`DEPTH`, provides storage, pointers and `count` through push/pop/full/empty ports.
- `src_queue` contains:
  - Op legality decode.
  - Operand mux.
  - Push/pop gating against full/empty.
  - The `rd_*` registers.
  - Sticky error logic.

## Test plan
1. **Reset:** reset, then idle with `op_valid`=0 and `write`/`source`=X for 5 cycles → `count`=0, `empty`=1, no `rd_valid`, no errors.
2. **Ordering:** push A=8'h11, push B=8'h22, pop, pop → `rd_data` 8'h11 then 8'h22 on consecutive strobes; `count` goes 1,2,1,0.
3. **Overflow:** push 5 values 8'h01..8'h05 with DEPTH=4 → `full`=1 after the 4th and `err_ovf`=1 after the 5th. Four pops return 01..04, then `empty`=1.
4. **Underflow and clear:** pop when empty → `rd_valid`=0 and `err_udf`=1. Then pulse `clr_err` → `err_udf`=0. Then `clr_err` in the same cycle as another empty pop → `err_udf` stays 1.
5. **Illegal pairs:** (1, 11), (0, 00) and (x, 01) with `op_valid`=1 → `err_illegal`=1; `count` and `rd_valid` unchanged.
6. **Wrap-around and mid-op reset:**
   - Push/pop 10 alternating values → all returned in order across pointer wrap.
   - Then push 3 and assert `rst` concurrently with a pop → after reset `count`=0 and `rd_valid`=0.
